arb_grant_collect: RTL and testbench
====================================

// Module: arb_grant_collect
// PURPOSE
//  Downstream stage of the 8-way rotating-priority arbiter. Consumes the arbiter's registered
//  one-hot grant, captures the winning requester's payload into a small FIFO and acks that
//  requester. Drains the FIFO onto one valid/ready output carrying data plus source index.
//  Drives arb_hold so the top level can mask requests into the arbiter while the FIFO is full.
// PARAMETERS
//  NREQ   8   number of requesters; must match arbiter width
//  DW     32  payload width per requester
//  DEPTH  4   capture FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          asynchronous reset, active low
//  req        in   NREQ       live request vector, same vector that feeds the arbiter
//  req_data   in   NREQ*DW    payloads; requester i uses bits [i*DW +: DW]
//  gnt        in   NREQ       registered one-hot grant from the arbiter
//  ack        out  NREQ       one-hot, combinational; ack[i]=1 means payload i captured this cycle
//  arb_hold   out  1          registered; 1 when FIFO count == DEPTH
//  out_valid  out  1          FIFO not empty
//  out_ready  in   1          downstream accept
//  out_data   out  DW         head payload
//  out_src    out  SRC_W      head source index, 0..NREQ-1
//  drop_cnt   out  16         saturating count of qualified grants lost to a full FIFO
//  err_gnt    out  1          sticky; set when gnt has more than one bit set
// BEHAVIOUR
//  Reset (rst_n=0, async): FIFO empty, out_valid=0, arb_hold=0, drop_cnt=0, err_gnt=0.
//   out_data/out_src are don't-care while out_valid=0. ack is 0 during reset.
//  qual = gnt & req. A grant is stale when the requester already dropped req after an ack,
//   because the arbiter grant lags req by one cycle. Stale grants are ignored silently:
//   no push, no ack, no drop count.
//  pop  = out_valid & out_ready.
//  room = (count < DEPTH) | pop. Full-FIFO push is allowed in the same cycle as a pop.
//  push = onehot(qual) & room. On push, write {idx(qual), req_data[idx]} at the clock edge.
//   ack = qual is driven in the same cycle; otherwise ack = 0.
//  Qualified one-hot grant with no room: no push, no ack, drop_cnt += 1 (saturates at 16'hFFFF).
//   The requester keeps req high and is re-arbitrated later.
//  |qual| > 1: err_gnt <= 1 (sticky until reset), no push, no ack, no drop count.
//   gnt itself with more than one bit set also sets err_gnt, even if qual is one-hot.
//  Latency: a gnt captured at edge t gives earliest out_valid in cycle t+1 (empty FIFO).
//  FIFO order is strict FIFO. Pointers are log2(DEPTH)+1 bits wide, with a wrap bit for
//   the full/empty distinction. Pointers wrap modulo 2*DEPTH.
//  arb_hold is registered from next-count == DEPTH, so it asserts the cycle after the final push.
//   The combinational room/drop logic stays authoritative.
//  Output side has no combinational path from out_ready to out_valid or out_data.
// STRUCTURE
//  Package arb_pkg:
//   - NREQ_DEF=8, SRC_W=$clog2(NREQ)
//   - function onehot_idx(vec) -> SRC_W index
//   - function is_onehot(vec) -> bit
//  Sub-module arb_sync_fifo #(W, DEPTH):
//   - ports push/pop/wdata/rdata/count/full/empty
//   - storage is a reg array; no reset on data, reset on pointers
//  Top holds the qual/room/ack/drop/err logic and instantiates one arb_sync_fifo, W=DW+SRC_W.
// TESTING
//  1. Single capture: req=8'h04, gnt=8'h04, data2=32'hA5A5_0002, out_ready=1.
//     Expect ack=8'h04 in the same cycle; next cycle out_valid=1, out_src=2, out_data=A5A5_0002.
//  2. Stale grant: ack to src 5 at cycle t, req[5] drops at t+1 while gnt=8'h20 at t+1.
//     Expect no ack, no push, drop_cnt unchanged.
//  3. Fill and drop: out_ready=0, four grants to src 0..3.
//     Expect arb_hold=1 after the 4th; a 5th grant to src 4 gives ack=0, drop_cnt=1.
//     Then out_ready=1 with grant to src 4: push and pop in the same cycle, ack=8'h10.
//  4. Order/wrap: 10 grants src 7,6,..,0,7,6 with random out_ready stalls.
//     Expect output sources in identical order and no loss; pointers wrap.
//  5. Bad grant: gnt=8'h11 with req=8'h11.
//     Expect err_gnt=1 next cycle and staying 1; no ack, FIFO count unchanged.
//  6. Reset mid-operation: rst_n low with 3 entries queued.
//     Expect out_valid=0, arb_hold=0, drop_cnt=0, err_gnt=0 immediately.
//     After release, first grant behaves as in test 1.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and grant-vector helpers for the arbiter grant-collection stage.
// Index extraction and bit counting are kept here so every consumer decodes grants the same way.
package arb_pkg;

  localparam int NREQ_DEF = 8;
  localparam int SRC_W    = $clog2(NREQ_DEF);
  localparam int CNT_W    = $clog2(NREQ_DEF + 1);

  // Number of set bits in a grant/request vector.
  function automatic logic [CNT_W-1:0] pop_count(input logic [NREQ_DEF-1:0] vec);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREQ_DEF; i++) begin
      cnt = cnt + CNT_W'(vec[i]);
    end
    return cnt;
  endfunction

  // Binary index of a one-hot vector; meaningless for other inputs.
  function automatic logic [SRC_W-1:0] onehot_idx(input logic [NREQ_DEF-1:0] vec);
    logic [SRC_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ_DEF; i++) begin
      if (vec[i]) begin
        idx = idx | SRC_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [NREQ_DEF-1:0] vec);
    return pop_count(vec) == CNT_W'(1);
  endfunction

  function automatic logic is_multihot(input logic [NREQ_DEF-1:0] vec);
    return pop_count(vec) > CNT_W'(1);
  endfunction

endpackage

// File: rtl/arb_grant_collect_chk.sv
// Property checker bound into arb_grant_collect: ack shape, output hold-stability, sticky error.
module arb_grant_collect_chk #(
  parameter int NREQ  = 8,
  parameter int DW    = 32,
  parameter int SRC_W = 3
) (
  input logic             clk,
  input logic             rst_n,
  input logic [NREQ-1:0]  req,
  input logic [NREQ-1:0]  gnt,
  input logic [NREQ-1:0]  ack,
  input logic             out_valid,
  input logic             out_ready,
  input logic [DW-1:0]    out_data,
  input logic [SRC_W-1:0] out_src,
  input logic             err_gnt
);

  a_ack_onehot0 : assert property (@(posedge clk) $onehot0(ack));

  a_ack_qualified : assert property (@(posedge clk) (ack & ~(req & gnt)) == '0);

  // A stalled head must not change or disappear.
  a_out_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_src)));

  a_err_sticky : assert property (@(posedge clk) disable iff (!rst_n)
    err_gnt |=> err_gnt);

endmodule

// File: rtl/arb_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a combinational head read.
// Data storage is not reset; only the pointers are.
module arb_sync_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q;
  logic [AW:0]  wptr_d;
  logic [AW:0]  rptr_q;
  logic [AW:0]  rptr_d;

  // Pointer advance; the extra MSB wraps modulo 2*DEPTH to tell full from empty.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      wptr_d = wptr_q + PTR_INC;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_INC;
    end else begin
      rptr_d = rptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage write; a push into a full FIFO is only issued alongside a pop of the same slot.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

  assign rdata = mem_q[rptr_q[AW-1:0]];
  assign count = wptr_q - rptr_q;
  assign full  = (count == DEPTH_C);
  assign empty = (wptr_q == rptr_q);

endmodule

// File: rtl/arb_grant_collect.sv
// Collects the arbiter's one-hot grant: captures the winner's payload into a FIFO, acks it,
// counts grants lost to a full FIFO and flags malformed grants.
module arb_grant_collect
  import arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic                 arb_hold,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic [SRC_W-1:0]     out_src,
  output logic [15:0]          drop_cnt,
  output logic                 err_gnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DW + SRC_W;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_INC = {{AW{1'b0}}, 1'b1};

  logic [NREQ-1:0]  qual_s;
  logic             qual_one_s;
  logic             qual_multi_s;
  logic             gnt_multi_s;
  logic             pop_s;
  logic             room_s;
  logic             push_s;
  logic [SRC_W-1:0] cap_idx_s;
  logic [DW-1:0]    cap_data_s;
  logic [EW-1:0]    wdata_s;
  logic [EW-1:0]    rdata_s;
  logic [AW:0]      count_s;
  logic [AW:0]      count_nxt_s;
  logic             full_s;
  logic             empty_s;

  logic             arb_hold_q;
  logic             arb_hold_d;
  logic [15:0]      drop_cnt_q;
  logic [15:0]      drop_cnt_d;
  logic             err_gnt_q;
  logic             err_gnt_d;

  // Grant qualification, capture decision and ack. A grant whose req already fell is stale
  // (the arbiter lags req by a cycle) and is masked out by qual without any side effect.
  always_comb begin
    qual_s       = gnt & req;
    qual_one_s   = is_onehot(qual_s);
    qual_multi_s = is_multihot(qual_s);
    gnt_multi_s  = is_multihot(gnt);
    pop_s        = !empty_s && out_ready;
    room_s       = !full_s || pop_s;
    cap_idx_s    = onehot_idx(qual_s);
    cap_data_s   = req_data[int'(cap_idx_s)*DW +: DW];
    wdata_s      = {cap_idx_s, cap_data_s};
    push_s       = 1'b0;
    ack          = '0;
    if (rst_n && qual_one_s && room_s) begin
      push_s = 1'b1;
      ack    = qual_s;
    end else begin
      push_s = 1'b0;
      ack    = '0;
    end
  end

  // Occupancy look-ahead for arb_hold, drop counting and sticky grant error.
  always_comb begin
    count_nxt_s = count_s;
    drop_cnt_d  = drop_cnt_q;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_s + CNT_INC;
      2'b01:   count_nxt_s = count_s - CNT_INC;
      default: count_nxt_s = count_s;
    endcase
    arb_hold_d = (count_nxt_s == DEPTH_C);
    if (qual_one_s && !room_s && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
    err_gnt_d = err_gnt_q | qual_multi_s | gnt_multi_s;
  end

  // Status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_hold_q <= 1'b0;
      drop_cnt_q <= 16'd0;
      err_gnt_q  <= 1'b0;
    end else begin
      arb_hold_q <= arb_hold_d;
      drop_cnt_q <= drop_cnt_d;
      err_gnt_q  <= err_gnt_d;
    end
  end

  arb_sync_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wdata_s),
    .rdata (rdata_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  assign out_valid = !empty_s;
  assign out_data  = rdata_s[DW-1:0];
  assign out_src   = rdata_s[EW-1:DW];
  assign arb_hold  = arb_hold_q;
  assign drop_cnt  = drop_cnt_q;
  assign err_gnt   = err_gnt_q;

  arb_grant_collect_chk #(
    .NREQ  (NREQ),
    .DW    (DW),
    .SRC_W (SRC_W)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .err_gnt   (err_gnt)
  );

endmodule

// File: tb/tb_arb_grant_collect.sv
// Bench for arb_grant_collect: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_arb_grant_collect;
  import arb_pkg::*;

  localparam int NREQ  = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic              arb_hold;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [SRC_W-1:0]  out_src;
  logic [15:0]       drop_cnt;
  logic              err_gnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [SRC_W+DW-1:0] mq[$];
  int  m_drop = 0;
  bit  m_err  = 1'b0;
  bit  m_hold = 1'b0;
  bit  rec    = 1'b0;
  int  seen[$];

  arb_grant_collect #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt), .ack(ack),
    .arb_hold(arb_hold), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .drop_cnt(drop_cnt), .err_gnt(err_gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int pcnt(input logic [NREQ-1:0] v);
    int n = 0;
    for (int i = 0; i < NREQ; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Ack the model predicts for the current inputs and current model occupancy.
  function automatic logic [NREQ-1:0] exp_ack();
    logic [NREQ-1:0] q;
    bit room;
    if (!rst_n) return '0;
    q = gnt & req;
    if (pcnt(q) != 1) return '0;
    room = (mq.size() < DEPTH) || ((mq.size() > 0) && out_ready);
    return room ? q : '0;
  endfunction

  always @(negedge rst_n) begin
    mq.delete();
    m_drop = 0;
    m_err  = 1'b0;
    m_hold = 1'b0;
  end

  always @(posedge clk) begin : model
    logic [NREQ-1:0] q;
    int  n;
    bit  pop, room;
    if (rst_n) begin
      q    = gnt & req;
      n    = pcnt(q);
      pop  = (mq.size() > 0) && out_ready;
      room = (mq.size() < DEPTH) || pop;
      if (pcnt(gnt) > 1) m_err = 1'b1;
      if (n == 1 && !room && m_drop < 65535) m_drop++;
      if (pop) void'(mq.pop_front());
      if (n == 1 && room) mq.push_back({SRC_W'(idx_of(q)), req_data[idx_of(q)*DW +: DW]});
      m_hold = (mq.size() == DEPTH);
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_src", 64'(out_src), 64'(mq[0][SRC_W+DW-1:DW]));
      chk("out_data", 64'(out_data), 64'(mq[0][DW-1:0]));
    end
    chk("ack", 64'(ack), 64'(exp_ack()));
    chk("arb_hold", 64'(arb_hold), 64'(m_hold));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop[15:0]));
    chk("err_gnt", 64'(err_gnt), 64'(m_err));
    if (rec && out_valid && out_ready) seen.push_back(int'(out_src));
  end

  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] g, input logic rdy);
    @(posedge clk);
    #1;
    req = r;
    gnt = g;
    out_ready = rdy;
  endtask

  task automatic init_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 32'hA5A5_0000 | 32'(i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int exp_order[10];
    int src_list[10];
    int k;
    logic [NREQ-1:0] v;
    exp_order = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6};
    src_list  = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6};
    rst_n = 1'b0; req = '0; gnt = '0; out_ready = 1'b0;
    init_data();
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_hold", 64'(arb_hold), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_err", 64'(err_gnt), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    #10 rst_n = 1'b1;

    // Single capture
    step(8'h04, 8'h04, 1'b1); #3 chk("t1_ack", 64'(ack), 64'h04);
    step(8'h00, 8'h00, 1'b1); #3;
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_src", 64'(out_src), 64'd2);
    chk("t1_data", 64'(out_data), 64'hA5A5_0002);

    // Stale grant
    step(8'h20, 8'h20, 1'b1); #3 chk("t2_ack", 64'(ack), 64'h20);
    step(8'h00, 8'h20, 1'b1); #3;
    chk("t2_stale_ack", 64'(ack), 64'h00);
    chk("t2_src", 64'(out_src), 64'd5);
    step(8'h00, 8'h00, 1'b1); #3;
    chk("t2_empty", 64'(out_valid), 64'd0);
    chk("t2_drop", 64'(drop_cnt), 64'd0);

    // Fill and drop
    step(8'h01, 8'h01, 1'b0);
    step(8'h02, 8'h02, 1'b0);
    step(8'h04, 8'h04, 1'b0);
    step(8'h08, 8'h08, 1'b0);
    step(8'h10, 8'h10, 1'b0); #3;
    chk("t3_hold", 64'(arb_hold), 64'd1);
    chk("t3_full_ack", 64'(ack), 64'h00);
    step(8'h10, 8'h10, 1'b1); #3;
    chk("t3_drop", 64'(drop_cnt), 64'd1);
    chk("t3_pushpop_ack", 64'(ack), 64'h10);
    chk("t3_head", 64'(out_src), 64'd0);
    for (int i = 0; i < 5; i++) step(8'h00, 8'h00, 1'b1);

    // Order and pointer wrap under random stalls
    rec = 1'b1;
    k = 0;
    for (int c = 0; c < 400 && !(k == 10 && mq.size() == 0); c++) begin
      v = (k < 10) ? (8'h01 << src_list[k]) : 8'h00;
      step(v, v, 1'($urandom_range(0, 1)));
      if (k < 10) req_data[src_list[k]*DW +: DW] = 32'hC0DE_0000 + 32'(k);
      #3;
      if (k < 10 && exp_ack() != '0) k++;
    end
    step(8'h00, 8'h00, 1'b0);
    rec = 1'b0;
    chk("t4_accepted", 64'(k), 64'd10);
    chk("t4_seen_len", 64'(seen.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < seen.size()) chk("t4_order", 64'(seen[i]), 64'(exp_order[i]));
    end

    // Malformed grant
    step(8'h01, 8'h01, 1'b0);
    step(8'h11, 8'h11, 1'b0); #3 chk("t5_ack", 64'(ack), 64'h00);
    step(8'h00, 8'h00, 1'b0); #3;
    chk("t5_err", 64'(err_gnt), 64'd1);
    chk("t5_valid", 64'(out_valid), 64'd1);
    step(8'h00, 8'h00, 1'b1); #3 chk("t5_err_sticky", 64'(err_gnt), 64'd1);
    step(8'h00, 8'h00, 1'b0); #3 chk("t5_one_entry", 64'(out_valid), 64'd0);

    // Reset with entries queued
    init_data();
    step(8'h01, 8'h01, 1'b0);
    step(8'h02, 8'h02, 1'b0);
    step(8'h04, 8'h04, 1'b0);
    step(8'h00, 8'h00, 1'b0); #1;
    chk("t6_pre_valid", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_hold", 64'(arb_hold), 64'd0);
    chk("t6_drop", 64'(drop_cnt), 64'd0);
    chk("t6_err", 64'(err_gnt), 64'd0);
    chk("t6_ack", 64'(ack), 64'h00);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(8'h04, 8'h04, 1'b1); #3 chk("t6_cap_ack", 64'(ack), 64'h04);
    step(8'h00, 8'h00, 1'b1); #3;
    chk("t6_cap_valid", 64'(out_valid), 64'd1);
    chk("t6_cap_src", 64'(out_src), 64'd2);
    chk("t6_cap_data", 64'(out_data), 64'hA5A5_0002);
    step(8'h00, 8'h00, 1'b0);
    step(8'h00, 8'h00, 1'b0);
    #3;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
